modn_cascade_counter: RTL and testbench
=======================================

Name: modn_cascade_counter

Overview:
- Parametrised successor to the single-digit mod-10 counter.
- Chains DIGITS modulo-MODULUS digit stages into one multi-digit counter, for example a 0000..9999 decimal counter.
- Adds count enable, up/down direction, parallel load, terminal-count and wrap flags.
- Sits in the counters library as the general building block for display, timer and sequence-index counting.

Parameters:
- DIGITS, 4: number of cascaded digit stages; legal range 1..8.
- MODULUS, 10: modulus of every digit; each digit counts 0..MODULUS-1; legal range 2..16.
- DW, 4: bits per digit; 2^DW must be at least MODULUS; checked at elaboration with a fatal error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable; advances one step per clk while high.
- up_dn  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  DIGITS*DW  load value; digit k occupies bits [k*DW +: DW]; digit 0 is least significant.
- count  out  DIGITS*DW  current count, packed the same way as load_val.
- tc  out  1  terminal count, combinational.
- wrap  out  1  registered one-cycle pulse on full-count wrap.
- zero  out  1  registered; high when every digit is 0.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - Reset is synchronous, active-high, and applied only at a clk edge.
  - When rst is sampled high: count=0, wrap=0, zero=1. tc follows its equation (0 while en=0).
- Priority per edge: rst > load > en > hold.
- Load:
  - count takes load_val on the next edge.
  - Any digit whose load value is at least MODULUS is clamped to MODULUS-1.
  - wrap=0 on the load cycle.
  - en is ignored on that cycle.
- Increment (en=1, up_dn=1):
  - Digit 0 always steps.
  - Digit k steps only if digits 0..k-1 are all at MODULUS-1.
  - A stepping digit at MODULUS-1 becomes 0; otherwise it adds 1.
- Decrement (en=1, up_dn=0):
  - Digit k steps only if digits 0..k-1 are all 0.
  - A stepping digit at 0 becomes MODULUS-1; otherwise it subtracts 1.
- Digit carry/borrow is a combinational ripple within one cycle. Latency from en to updated count is 1 cycle.
- tc:
  - Equals en AND (all digits = MODULUS-1 when up_dn=1, or all digits = 0 when up_dn=0).
  - tc is suppressed while load=1 or rst=1.
  - Intended as the enable input of a further cascaded counter.
- wrap:
  - Goes high for exactly the one cycle after the edge on which the counter crossed full-scale: MODULUS^DIGITS-1 to 0, or 0 to MODULUS^DIGITS-1.
  - Otherwise 0.
- zero: registered; reflects the count that has just been written.
- Direction change: up_dn may toggle on any cycle and takes effect on that same edge; there is no pipeline bubble.
- en=0 holds count; wrap returns to 0.
- Reset mid-count or coincident with load/en: reset wins, and count is 0 on the next cycle.
- Illegal count values cannot arise, because load clamps digit values.
- Expected implementation size: roughly 150-250 lines of RTL.

Optional Feature:
- Macro: MODN_SATURATE_EN.
- When defined:
  - Counting saturates instead of wrapping. At all-(MODULUS-1) with up_dn=1, or all-0 with up_dn=0, an enabled step holds count.
  - wrap is never asserted and is tied to 0.
  - tc still asserts at the limit.
- When undefined: wrap-around behaviour as described in Behaviour.

Test Plan:
- Reset: DIGITS=2, MODULUS=10; hold rst=1 for 10 cycles with en=1 -> count=8'h00, zero=1, wrap=0 throughout; first increment occurs on the first edge after rst falls.
- Up count with wrap: en=1, up_dn=1 from 0 for 100 cycles -> digit sequence 00..99 with BCD carry from 09 to 10; tc=1 only while count=8'h99; the next edge gives 8'h00 and wrap=1 for one cycle.
- Down count with borrow: load 8'h10, then en=1, up_dn=0 -> 8'h09, 8'h08 ... 8'h00; tc=1 at 00; the next edge gives 8'h99 and wrap=1.
- Load clamp and priority: load=1, en=1, load_val=8'hC3 -> count=8'h93 (upper digit clamped to 9) and no step is taken that cycle.
- Mid-operation events: count at 8'h57; toggle up_dn each cycle -> 56, 57, 56; assert rst together with load=1 -> count=8'h00.
- MODN_SATURATE_EN build: count at 8'h99 with en=1, up_dn=1 for 5 cycles -> count stays 8'h99, tc=1, wrap=0.

Source files
------------

// File: rtl/modn_cascade_counter.sv
// Multi-digit modulo-MODULUS cascade counter with enable, direction, clamped load, tc/wrap/zero flags.
// Optional macro MODN_SATURATE_EN: counting holds at the full-scale limits and wrap stays 0.
module modn_cascade_counter #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10,
  parameter int DW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap,
  output logic                 zero
);

  localparam int              CW      = DIGITS * DW;
  localparam logic [DW-1:0]   MAX_DIG = DW'(MODULUS - 1);

  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $fatal(1, "modn_cascade_counter: DIGITS must be in 1..8");
    end
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
      $fatal(1, "modn_cascade_counter: MODULUS must be in 2..16");
    end
    if ((2 ** DW) < MODULUS) begin : g_bad_dw
      $fatal(1, "modn_cascade_counter: DW too narrow for MODULUS");
    end
  endgenerate

  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic          zero_q, zero_d;
  logic          at_limit;
  logic          carry;
  logic [DW-1:0] dig;
  logic [DW-1:0] nxt;

  // Every digit sits at the limit for the current direction: the whole counter is at full scale.
  always_comb begin
    at_limit = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (count_q[k*DW +: DW] != (up_dn ? MAX_DIG : '0)) begin
        at_limit = 1'b0;
      end
    end
  end

  assign tc = en & at_limit & ~load & ~rst;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    dig     = '0;
    nxt     = '0;
    if (load) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        dig = load_val[k*DW +: DW];
        count_d[k*DW +: DW] = (dig > MAX_DIG) ? MAX_DIG : dig;
      end
    end else if (en) begin
      // Ripple: a digit steps only while every lower digit is at its direction's limit.
      for (int unsigned k = 0; k < DIGITS; k++) begin
        dig = count_q[k*DW +: DW];
        nxt = dig;
        if (carry) begin
          if (up_dn) begin
            nxt = (dig == MAX_DIG) ? '0 : dig + DW'(1);
          end else begin
            nxt = (dig == '0) ? MAX_DIG : dig - DW'(1);
          end
        end
        count_d[k*DW +: DW] = nxt;
        carry = carry & (up_dn ? (dig == MAX_DIG) : (dig == '0));
      end
`ifdef MODN_SATURATE_EN
      if (at_limit) begin
        count_d = count_q;
      end
`else
      wrap_d = at_limit;
`endif
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      zero_q  <= zero_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Self-checking bench for modn_cascade_counter (DIGITS=2, MODULUS=10) against an integer-valued reference model.
module tb_modn_cascade_counter;

  localparam int D    = 2;
  localparam int MOD  = 10;
  localparam int W    = 4;
  localparam int FULL = MOD ** D;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           up_dn = 1'b1;
  logic           load = 1'b0;
  logic [D*W-1:0] load_val = '0;
  logic [D*W-1:0] count;
  logic           tc;
  logic           wrap;
  logic           zero;

  int checks = 0;
  int failures = 0;

  int   m_val  = 0;
  logic m_wrap = 1'b0;
  logic m_zero = 1'b1;
  logic exp_tc;
  logic tc_seen;

  modn_cascade_counter #(.DIGITS(D), .MODULUS(MOD), .DW(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [D*W-1:0] to_packed(input int v);
    logic [D*W-1:0] p;
    p = '0;
    for (int k = 0; k < D; k++) p[k*W +: W] = W'((v / (MOD ** k)) % MOD);
    return p;
  endfunction

  function automatic int clamp_value(input logic [D*W-1:0] lv);
    int v;
    int d;
    v = 0;
    for (int k = 0; k < D; k++) begin
      d = int'(lv[k*W +: W]);
      if (d >= MOD) d = MOD - 1;
      v = v + d * (MOD ** k);
    end
    return v;
  endfunction

  // One clock: drive inputs, sample tc before the edge, then advance the reference model.
  task automatic apply(input logic r, input logic l, input logic e, input logic u,
                       input logic [D*W-1:0] lv);
    rst = r; load = l; en = e; up_dn = u; load_val = lv;
    #1;
    tc_seen = tc;
    exp_tc  = e && !l && !r && (u ? (m_val == FULL - 1) : (m_val == 0));
    @(posedge clk);
    #1;
    m_wrap = 1'b0;
    if (r) begin
      m_val = 0;
    end else if (l) begin
      m_val = clamp_value(lv);
    end else if (e) begin
      if (u) begin
        if (m_val == FULL - 1) begin
`ifdef MODN_SATURATE_EN
          m_val = m_val;
`else
          m_val = 0; m_wrap = 1'b1;
`endif
        end else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin
`ifdef MODN_SATURATE_EN
          m_val = 0;
`else
          m_val = FULL - 1; m_wrap = 1'b1;
`endif
        end else m_val = m_val - 1;
      end
    end
    m_zero = (m_val == 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b1, '0);
      checks++;
      if ({count, wrap, zero, tc_seen} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL reset cyc=%0d count=%h wrap=%b zero=%b tc=%b want count=00 wrap=0 zero=1 tc=0",
                 i, count, wrap, zero, tc_seen);
      end
    end
    apply(1'b0, 1'b0, 1'b1, 1'b1, '0);
    checks++;
    if ({count, zero} !== {8'h01, 1'b0}) begin
      failures++;
      $display("FAIL reset_first_inc count=%h zero=%b want count=01 zero=0", count, zero);
    end
  endtask

  task automatic test_up_wrap();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < FULL + 1; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b1, '0);
      checks++;
      if ({count, wrap, zero, tc_seen} !== {to_packed(m_val), m_wrap, m_zero, exp_tc}) begin
        failures++;
        $display("FAIL up_wrap step=%0d count=%h wrap=%b zero=%b tc=%b want count=%h wrap=%b zero=%b tc=%b",
                 i, count, wrap, zero, tc_seen, to_packed(m_val), m_wrap, m_zero, exp_tc);
      end
    end
  endtask

  task automatic test_down_borrow();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    checks++;
    if (count !== 8'h10) begin
      failures++;
      $display("FAIL down_load count=%h want 10", count);
    end
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if ({count, wrap, zero, tc_seen} !== {to_packed(m_val), m_wrap, m_zero, exp_tc}) begin
        failures++;
        $display("FAIL down_borrow step=%0d count=%h wrap=%b zero=%b tc=%b want count=%h wrap=%b zero=%b tc=%b",
                 i, count, wrap, zero, tc_seen, to_packed(m_val), m_wrap, m_zero, exp_tc);
      end
    end
  endtask

  task automatic test_load_clamp();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hC3);
    checks++;
    if ({count, wrap, tc_seen} !== {8'h93, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_clamp count=%h wrap=%b tc=%b want count=93 wrap=0 tc=0", count, wrap, tc_seen);
    end
  endtask

  task automatic test_mid_ops();
    logic [D*W-1:0] want [3];
    want[0] = 8'h56; want[1] = 8'h57; want[2] = 8'h56;
    apply(1'b0, 1'b1, 1'b0, 1'b1, 8'h57);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1, (i % 2 == 1), '0);
      checks++;
      if (count !== want[i]) begin
        failures++;
        $display("FAIL dir_toggle step=%0d count=%h want %h", i, count, want[i]);
      end
    end
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
    checks++;
    if ({count, zero, wrap, tc_seen} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_over_load count=%h zero=%b wrap=%b tc=%b want count=00 zero=1 wrap=0 tc=0",
               count, zero, wrap, tc_seen);
    end
  endtask

  task automatic test_limit_hold();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b1, '0);
      checks++;
      if ({count, wrap, zero, tc_seen} !== {to_packed(m_val), m_wrap, m_zero, exp_tc}) begin
        failures++;
        $display("FAIL limit_hold step=%0d count=%h wrap=%b zero=%b tc=%b want count=%h wrap=%b zero=%b tc=%b",
                 i, count, wrap, zero, tc_seen, to_packed(m_val), m_wrap, m_zero, exp_tc);
      end
    end
  endtask

  task automatic test_random();
    logic r, l, e, u;
    logic [D*W-1:0] lv;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      lv = (D*W)'($urandom);
      apply(r, l, e, u, lv);
      checks++;
      if ({count, wrap, zero, tc_seen} !== {to_packed(m_val), m_wrap, m_zero, exp_tc}) begin
        failures++;
        $display("FAIL random i=%0d rst=%b load=%b en=%b up=%b lv=%h count=%h wrap=%b zero=%b tc=%b want count=%h wrap=%b zero=%b tc=%b",
                 i, r, l, e, u, lv, count, wrap, zero, tc_seen, to_packed(m_val), m_wrap, m_zero, exp_tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_load_clamp();
    test_mid_ops();
    test_limit_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
